mvu_pe_acc: RTL and testbench

- Consumer end of the PE SIMD product interface.
- Takes the SIMD lane products of one PE (one TDstI-bit word per lane, from the binary or standard SIMD units), reduces them through a registered adder stage, and accumulates across SF synapse folds.
- Emits one TO-bit dot-product result per output neuron with a single-cycle valid strobe toward the MVAU stream output / threshold stage.
- Sits inside mvu_pe, directly downstream of the SIMD instances.

---
 rtl/mvau_defn.sv | 26 ++
 rtl/mvu_pe_adders.sv | 72 +++++++
 rtl/mvu_pe_acc.sv | 88 ++++++++
 tb/tb_mvu_pe_acc.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvau_defn.sv
// ---------------------------------------------------------------------------
// mvau_defn: shared MVAU stream definitions.
//   Default datapath geometry for a PE (SIMD lanes, lane product width,
//   synapse folds, accumulator width) plus helpers that derive the widths
//   the stream sub-blocks need from their own parameter overrides.
// ---------------------------------------------------------------------------
package mvau_defn;

  localparam int SIMD  = 2;   // SIMD lanes feeding one PE
  localparam int TDstI = 4;   // unsigned lane product width
  localparam int SF    = 4;   // synapse folds accumulated per output
  localparam int TO    = 8;   // accumulator / output width (modulo 2^TO)

  // Full-precision width of the lane reduction: no carry can be lost.
  localparam int SUMW  = TDstI + $clog2(SIMD);

  function automatic int sum_width(input int tdsti, input int simd);
    return tdsti + $clog2(simd);
  endfunction

  // A fold counter always needs at least one bit, even when SF == 1.
  function automatic int cnt_width(input int sf);
    return (sf > 1) ? $clog2(sf) : 1;
  endfunction

endpackage

// File: rtl/mvu_pe_adders.sv
// ---------------------------------------------------------------------------
// mvu_pe_adders: lane reduction for one PE.
//   Adds the SIMD unsigned lane products at full precision, then resizes the
//   sum to OW bits (zero-extend or truncate). With REG=1 the result and its
//   valid are registered and advance only while en=1; with REG=0 the block
//   is purely combinational.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (REG=1 only)
//   en          stage enable; 0 holds the registered sum and valid
//   in_v        lane products valid
//   in_simd     packed lane products, lane k = [k*TDstI +: TDstI]
//   out_v       reduced-sum valid
//   out_sum     reduced sum, OW bits
// ---------------------------------------------------------------------------
module mvu_pe_adders #(
  parameter int SIMD  = mvau_defn::SIMD,
  parameter int TDstI = mvau_defn::TDstI,
  parameter int OW    = mvau_defn::TO,
  parameter bit REG   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_v,
  input  logic [SIMD*TDstI-1:0]   in_simd,
  output logic                    out_v,
  output logic [OW-1:0]           out_sum
);

  localparam int SUMW = mvau_defn::sum_width(TDstI, SIMD);

  logic [SUMW-1:0] w_sum;
  logic [OW-1:0]   w_sum_ow;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < SIMD; k++) begin
      w_sum = w_sum + SUMW'(in_simd[k*TDstI +: TDstI]);
    end
  end

  // Unsigned size cast: zero-extends when OW > SUMW, truncates otherwise.
  assign w_sum_ow = OW'(w_sum);

  generate
    if (REG) begin : g_reg
      logic          r_v;
      logic [OW-1:0] r_sum;

      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_v   <= 1'b0;
          r_sum <= '0;
        end else if (en) begin
          r_v   <= in_v;
          r_sum <= w_sum_ow;
        end
      end

      assign out_v   = r_v;
      assign out_sum = r_sum;
    end else begin : g_comb
      assign out_v   = in_v;
      assign out_sum = w_sum_ow;
    end
  endgenerate

endmodule

// File: rtl/mvu_pe_acc.sv
// ---------------------------------------------------------------------------
// mvu_pe_acc: PE accumulator, consumer end of the SIMD product interface.
//   Stage 1 reduces the SIMD lane products (registered adder stage).
//   Stage 2 accumulates SF reduced sums per output neuron and emits the
//   TO-bit result with a single-cycle valid pulse. do_mvau_stream=0 freezes
//   both stages; only a pending out_v pulse still clears.
// Ports:
//   clk             main clock
//   rst_n           synchronous, active-low reset
//   do_mvau_stream  pipeline enable
//   in_v            lane products valid
//   in_simd         packed lane products, lane k = [k*TDstI +: TDstI]
//   out_v           result valid, one-cycle pulse
//   out             accumulated dot product (held until the next result)
// ---------------------------------------------------------------------------
module mvu_pe_acc #(
  parameter int SIMD  = mvau_defn::SIMD,
  parameter int TDstI = mvau_defn::TDstI,
  parameter int SF    = mvau_defn::SF,
  parameter int TO    = mvau_defn::TO
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    do_mvau_stream,
  input  logic                    in_v,
  input  logic [SIMD*TDstI-1:0]   in_simd,
  output logic                    out_v,
  output logic [TO-1:0]           out
);

  localparam int              CNTW = mvau_defn::cnt_width(SF);
  localparam logic [CNTW-1:0] LAST = CNTW'(SF - 1);

  logic            w_sum_v;
  logic [TO-1:0]   w_sum_r;
  logic [TO-1:0]   w_acc_next;

  logic [TO-1:0]   r_acc;
  logic [CNTW-1:0] r_sf_cnt;
  logic [TO-1:0]   r_out;
  logic            r_out_v;

  // Stage 1: registered lane reduction.
  mvu_pe_adders #(
    .SIMD  (SIMD),
    .TDstI (TDstI),
    .OW    (TO),
    .REG   (1'b1)
  ) u_adders (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (do_mvau_stream),
    .in_v    (in_v),
    .in_simd (in_simd),
    .out_v   (w_sum_v),
    .out_sum (w_sum_r)
  );

  // Fold 0 restarts the accumulator, so back-to-back neurons need no gap.
  assign w_acc_next = (r_sf_cnt == '0) ? w_sum_r : r_acc + w_sum_r;

  // Stage 2: accumulate, count folds, emit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_sf_cnt <= '0;
      r_out    <= '0;
      r_out_v  <= 1'b0;
    end else begin
      // The pulse drops on the next edge even while the pipeline is frozen.
      r_out_v <= 1'b0;
      if (do_mvau_stream && w_sum_v) begin
        r_acc <= w_acc_next;
        if (r_sf_cnt == LAST) begin
          r_out    <= w_acc_next;
          r_out_v  <= 1'b1;
          r_sf_cnt <= '0;
        end else begin
          r_sf_cnt <= r_sf_cnt + 1'b1;
        end
      end
    end
  end

  assign out   = r_out;
  assign out_v = r_out_v;

endmodule

// File: tb/tb_mvu_pe_acc.sv
// ---------------------------------------------------------------------------
// tb_mvu_pe_acc: bench for mvu_pe_acc.
//   Two instances share the stimulus: SF=4 (main) and SF=16 (wrap case).
//   Each cycle's inputs are recorded; the expected pulse/value trace is
//   derived from the accumulation rules: every SF accepted inputs form one
//   result (sum mod 256), visible after the first enabled edge following the
//   last fold, for one cycle; out holds the last result.
// ---------------------------------------------------------------------------
module tb_mvu_pe_acc;

  localparam int MAXC = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_v;
  logic [7:0] in_simd;
  logic       out_v;
  logic [7:0] out_d;
  logic       out_v16;
  logic [7:0] out16;

  always #5 clk = ~clk;

  mvu_pe_acc #(.SIMD(2), .TDstI(4), .SF(4), .TO(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .do_mvau_stream (en),
    .in_v           (in_v),
    .in_simd        (in_simd),
    .out_v          (out_v),
    .out            (out_d)
  );

  mvu_pe_acc #(.SIMD(2), .TDstI(4), .SF(16), .TO(8)) dut16 (
    .clk            (clk),
    .rst_n          (rst_n),
    .do_mvau_stream (en),
    .in_v           (in_v),
    .in_simd        (in_simd),
    .out_v          (out_v16),
    .out            (out16)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus program and observed / expected traces, one entry per edge.
  int n;
  bit st_en [MAXC];
  bit st_v  [MAXC];
  int st_l0 [MAXC];
  int st_l1 [MAXC];
  bit obs_v   [MAXC];
  int obs_out [MAXC];
  bit obs16_v   [MAXC];
  int obs16_out [MAXC];
  bit exp_v   [MAXC];
  int exp_out [MAXC];

  task automatic add_step(input bit e, input bit v, input int l0, input int l1);
    st_en[n] = e;
    st_v[n]  = v;
    st_l0[n] = l0;
    st_l1[n] = l1;
    n++;
  endtask

  task automatic add_folds(input int cnt, input int l0, input int l1);
    for (int i = 0; i < cnt; i++) add_step(1'b1, 1'b1, l0, l1);
  endtask

  task automatic add_idle(input int cnt);
    for (int i = 0; i < cnt; i++) add_step(1'b1, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; in_v = 1'b0; in_simd = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
  endtask

  // Apply the recorded program; drive on negedge, sample #1 after posedge.
  task automatic run();
    logic [3:0] l0, l1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      l0 = st_l0[i][3:0];
      l1 = st_l1[i][3:0];
      en = st_en[i]; in_v = st_v[i]; in_simd = {l1, l0};
      @(posedge clk);
      #1;
      obs_v[i]     = out_v;
      obs_out[i]   = int'(out_d);
      obs16_v[i]   = out_v16;
      obs16_out[i] = int'(out16);
    end
    @(negedge clk);
    en = 1'b0; in_v = 1'b0;
  endtask

  // Reference: trace expected out_v/out for a given fold count, starting
  // from a freshly reset accumulator (out = 0).
  task automatic build_expected(input int sf);
    int acc, folds, last;
    int ev [MAXC];
    acc = 0; folds = 0; last = 0;
    for (int i = 0; i < n; i++) begin
      exp_v[i] = 1'b0;
      ev[i]    = 0;
    end
    for (int c = 0; c < n; c++) begin
      if (st_en[c] && st_v[c]) begin
        acc = acc + st_l0[c] + st_l1[c];
        folds++;
        if (folds == sf) begin
          for (int e = c + 1; e < n; e++) begin
            if (st_en[e]) begin
              exp_v[e] = 1'b1;
              ev[e]    = acc % 256;
              break;
            end
          end
          acc = 0; folds = 0;
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      if (exp_v[i]) last = ev[i];
      exp_out[i] = last;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; in_v = 1'b1; in_simd = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_v !== 1'b0)   begin bad++; $display("FAIL reset_out_v: got %b want 0", out_v); end
    total++; if (out_d !== 8'd0)   begin bad++; $display("FAIL reset_out: got %0d want 0", out_d); end
    total++; if (out_v16 !== 1'b0) begin bad++; $display("FAIL reset_out_v16: got %b want 0", out_v16); end
    total++; if (out16 !== 8'd0)   begin bad++; $display("FAIL reset_out16: got %0d want 0", out16); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; in_v = 1'b0;
  endtask

  task automatic test_basic();
    int pulses = 0;
    do_reset();
    add_folds(4, 1, 2);
    add_idle(3);
    run();
    build_expected(4);
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_v[i] !== exp_v[i] || obs_out[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL basic edge %0d: got v=%0b out=%0d want v=%0b out=%0d",
                 i, obs_v[i], obs_out[i], exp_v[i], exp_out[i]);
      end
      pulses += int'(obs_v[i]);
    end
    total++;
    if (obs_v[4] !== 1'b1 || obs_out[4] !== 12) begin
      bad++; $display("FAIL basic_result: got v=%0b out=%0d want v=1 out=12", obs_v[4], obs_out[4]);
    end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_reset();
    add_folds(8, 3, 3);
    add_idle(3);
    run();
    build_expected(4);
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_v[i] !== exp_v[i] || obs_out[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL b2b edge %0d: got v=%0b out=%0d want v=%0b out=%0d",
                 i, obs_v[i], obs_out[i], exp_v[i], exp_out[i]);
      end
      pulses += int'(obs_v[i]);
    end
    total++;
    if (obs_v[4] !== 1'b1 || obs_out[4] !== 24 || obs_v[8] !== 1'b1 || obs_out[8] !== 24) begin
      bad++;
      $display("FAIL b2b_results: got e4 v=%0b out=%0d e8 v=%0b out=%0d want both v=1 out=24",
               obs_v[4], obs_out[4], obs_v[8], obs_out[8]);
    end
    total++;
    if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_stall();
    int pulses = 0;
    do_reset();
    add_folds(2, 2, 1);
    for (int i = 0; i < 3; i++) add_step(1'b0, 1'b1, 15, 15);  // ignored while frozen
    add_folds(2, 2, 1);
    add_idle(1);
    add_step(1'b0, 1'b0, 0, 0);                               // pulse must still clear
    add_idle(2);
    run();
    build_expected(4);
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_v[i] !== exp_v[i] || obs_out[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL stall edge %0d: got v=%0b out=%0d want v=%0b out=%0d",
                 i, obs_v[i], obs_out[i], exp_v[i], exp_out[i]);
      end
      pulses += int'(obs_v[i]);
    end
    total++;
    if (obs_v[7] !== 1'b1 || obs_out[7] !== 12 || obs_v[8] !== 1'b0) begin
      bad++;
      $display("FAIL stall_result: got e7 v=%0b out=%0d e8 v=%0b want e7 v=1 out=12 e8 v=0",
               obs_v[7], obs_out[7], obs_v[8]);
    end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_bubbles();
    do_reset();
    add_folds(1, 1, 2);
    add_idle(1);
    add_folds(1, 1, 2);
    add_idle(2);
    add_folds(2, 1, 2);
    add_idle(3);
    run();
    build_expected(4);
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_v[i] !== exp_v[i] || obs_out[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL bubble edge %0d: got v=%0b out=%0d want v=%0b out=%0d",
                 i, obs_v[i], obs_out[i], exp_v[i], exp_out[i]);
      end
    end
    total++;
    if (obs_v[7] !== 1'b1 || obs_out[7] !== 12) begin
      bad++; $display("FAIL bubble_result: got v=%0b out=%0d want v=1 out=12", obs_v[7], obs_out[7]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    add_folds(16, 15, 15);
    add_idle(3);
    run();
    build_expected(16);
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs16_v[i] !== exp_v[i] || obs16_out[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL wrap edge %0d: got v=%0b out=%0d want v=%0b out=%0d",
                 i, obs16_v[i], obs16_out[i], exp_v[i], exp_out[i]);
      end
    end
    total++;
    if (obs16_v[16] !== 1'b1 || obs16_out[16] !== 224) begin
      bad++; $display("FAIL wrap_result: got v=%0b out=%0d want v=1 out=224", obs16_v[16], obs16_out[16]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_folds(4, 1, 2);
    add_idle(2);
    run();
    total++;
    if (obs_out[n-1] !== 12) begin bad++; $display("FAIL rmid_first: got %0d want 12", obs_out[n-1]); end
    n = 0;
    add_folds(3, 3, 3);
    run();
    // Reset while a fold is pending in the reduce stage and inputs stay active.
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; in_v = 1'b1; in_simd = 8'h33;
    @(posedge clk);
    #1;
    total++;
    if (out_d !== 8'd0 || out_v !== 1'b0) begin
      bad++; $display("FAIL rmid_reset: got v=%0b out=%0d want v=0 out=0", out_v, out_d);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; in_v = 1'b0;
    n = 0;
    add_folds(4, 1, 1);
    add_idle(2);
    run();
    build_expected(4);
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_v[i] !== exp_v[i] || obs_out[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL rmid edge %0d: got v=%0b out=%0d want v=%0b out=%0d",
                 i, obs_v[i], obs_out[i], exp_v[i], exp_out[i]);
      end
    end
    total++;
    if (obs_v[4] !== 1'b1 || obs_out[4] !== 8) begin
      bad++; $display("FAIL rmid_result: got v=%0b out=%0d want v=1 out=8", obs_v[4], obs_out[4]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 150; i++) begin
      add_step($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7,
               int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
    end
    add_idle(3);
    run();
    build_expected(4);
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_v[i] !== exp_v[i] || obs_out[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL rand4 edge %0d: got v=%0b out=%0d want v=%0b out=%0d",
                 i, obs_v[i], obs_out[i], exp_v[i], exp_out[i]);
      end
    end
    build_expected(16);
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs16_v[i] !== exp_v[i] || obs16_out[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL rand16 edge %0d: got v=%0b out=%0d want v=%0b out=%0d",
                 i, obs16_v[i], obs16_out[i], exp_v[i], exp_out[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_v = 1'b0; in_simd = '0; n = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
